// File: rtl/exc_seq_ctrl_pkg.sv
// Shared definitions for the exception/ERET sequencer: cause codes, FSM states
// and the bit positions of the request one-hot used by the priority encoder.
package exc_seq_ctrl_pkg;

  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_TEQ     = 5'd13;

  // Request one-hot positions, highest priority first.
  localparam int unsigned W_SYSCALL = 0;
  localparam int unsigned W_BREAK   = 1;
  localparam int unsigned W_TEQ     = 2;
  localparam int unsigned W_ERET    = 3;
  localparam int unsigned W_MTC0    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_ERET,
    S_FLUSH,
    S_REDIR
  } state_e;

endpackage

// File: rtl/exc_seq_ctrl_prio_enc.sv
// Fixed-priority request encoder (syscall > break > teq > eret > mtc0) with the
// CP0 status mask check applied to the winning exception.
module exc_prio_enc
  import exc_seq_ctrl_pkg::*;
(
  input  logic       syscall_req,
  input  logic       break_req,
  input  logic       teq_req,
  input  logic       eret_req,
  input  logic       mtc0_req,
  input  logic [3:0] status,
  output logic [4:0] winner,
  output logic [4:0] cause,
  output logic       winner_enabled
);

  // NOTE: every output gets a default first so no path through the if-chain infers a latch.
  always_comb begin
    winner         = '0;
    cause          = '0;
    winner_enabled = 1'b0;
    if (syscall_req) begin
      winner[W_SYSCALL] = 1'b1;
      cause             = EXC_SYSCALL;
      winner_enabled    = status[0] & status[1];
    end else if (break_req) begin
      winner[W_BREAK] = 1'b1;
      cause           = EXC_BREAK;
      winner_enabled  = status[0] & status[2];
    end else if (teq_req) begin
      winner[W_TEQ]  = 1'b1;
      cause          = EXC_TEQ;
      winner_enabled = status[0] & status[3];
    end else if (eret_req) begin
      winner[W_ERET] = 1'b1;
      winner_enabled = 1'b1;
    end else if (mtc0_req) begin
      winner[W_MTC0] = 1'b1;
      winner_enabled = 1'b1;
    end
  end

endmodule

// File: rtl/exc_seq_ctrl.sv
// Exception/ERET sequencer between MEM and CP0: issues CP0 command pulses,
// flushes the pipeline for FLUSH_CYC cycles and then redirects the PC.
module exc_seq_ctrl
  import exc_seq_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYC = 2,
  parameter logic [31:0] VEC_ADDR  = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_req,
  input  logic        break_req,
  input  logic        teq_req,
  input  logic        eret_req,
  input  logic        mtc0_req,
  input  logic [31:0] req_pc,
  input  logic [31:0] status,
  input  logic [31:0] epc,
  output logic        stall,
  output logic        flush,
  output logic        busy,
  output logic        cp0_exception,
  output logic [4:0]  cp0_cause,
  output logic [31:0] cp0_pc,
  output logic        cp0_eret,
  output logic        cp0_mtc0,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr
);

  localparam int unsigned CNT_W = $clog2(FLUSH_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYC - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        cause_q;
  logic [31:0]       pc_q;
  logic [31:0]       target_q;
  logic              exc_q;
  logic              eret_q;
  logic              flush_q;
  logic              redir_q;

  logic [4:0]        winner;
  logic [4:0]        win_cause;
  logic              win_en;
  logic              win_is_exc;
  logic              unused_status;

  // Only the global enable and the three per-exception enables matter here.
  assign unused_status = ^status[31:4];

  exc_prio_enc u_prio (
    .syscall_req    (syscall_req),
    .break_req      (break_req),
    .teq_req        (teq_req),
    .eret_req       (eret_req),
    .mtc0_req       (mtc0_req),
    .status         (status[3:0]),
    .winner         (winner),
    .cause          (win_cause),
    .winner_enabled (win_en)
  );

  assign win_is_exc = winner[W_SYSCALL] | winner[W_BREAK] | winner[W_TEQ];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cause_q  <= '0;
      pc_q     <= '0;
      target_q <= '0;
      exc_q    <= 1'b0;
      eret_q   <= 1'b0;
      flush_q  <= 1'b0;
      redir_q  <= 1'b0;
    end else begin
      exc_q   <= 1'b0;
      eret_q  <= 1'b0;
      flush_q <= 1'b0;
      redir_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // A masked exception wins arbitration but is simply dropped here.
          if (win_is_exc && win_en) begin
            state_q  <= S_ENTER;
            cause_q  <= win_cause;
            pc_q     <= req_pc;
            target_q <= VEC_ADDR;
            exc_q    <= 1'b1;
            flush_q  <= 1'b1;
          end else if (winner[W_ERET]) begin
            state_q  <= S_ERET;
            target_q <= epc;
            eret_q   <= 1'b1;
            flush_q  <= 1'b1;
          end
        end
        S_ENTER, S_ERET: begin
          state_q <= S_FLUSH;
          cnt_q   <= '0;
          flush_q <= 1'b1;
        end
        S_FLUSH: begin
          flush_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_REDIR;
            redir_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_REDIR: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign stall         = busy;
  assign flush         = flush_q;
  assign cp0_exception = exc_q;
  assign cp0_cause     = exc_q ? cause_q : 5'd0;
  assign cp0_pc        = exc_q ? pc_q : 32'd0;
  assign cp0_eret      = eret_q;
  assign cp0_mtc0      = (state_q == S_IDLE) & winner[W_MTC0];
  assign pc_redirect   = redir_q;
  assign redirect_addr = redir_q ? target_q : 32'd0;

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Directed self-checking bench for exc_seq_ctrl (FLUSH_CYC=2, VEC_ADDR=0x0040_0004).
module tb_exc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        syscall_req, break_req, teq_req, eret_req, mtc0_req;
  logic [31:0] req_pc, status, epc;
  logic        stall, flush, busy, cp0_exception, cp0_eret, cp0_mtc0, pc_redirect;
  logic [4:0]  cp0_cause;
  logic [31:0] cp0_pc, redirect_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_seq_ctrl #(.FLUSH_CYC(2), .VEC_ADDR(32'h0040_0004)) dut (
    .clk           (clk),
    .rst           (rst),
    .syscall_req   (syscall_req),
    .break_req     (break_req),
    .teq_req       (teq_req),
    .eret_req      (eret_req),
    .mtc0_req      (mtc0_req),
    .req_pc        (req_pc),
    .status        (status),
    .epc           (epc),
    .stall         (stall),
    .flush         (flush),
    .busy          (busy),
    .cp0_exception (cp0_exception),
    .cp0_cause     (cp0_cause),
    .cp0_pc        (cp0_pc),
    .cp0_eret      (cp0_eret),
    .cp0_mtc0      (cp0_mtc0),
    .pc_redirect   (pc_redirect),
    .redirect_addr (redirect_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes of the idle state: nothing pending towards CP0 or the PC mux.
  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " flush"}, 32'(flush), 32'd0);
    check({tag, " exc"}, 32'(cp0_exception), 32'd0);
    check({tag, " eret"}, 32'(cp0_eret), 32'd0);
    check({tag, " redir"}, 32'(pc_redirect), 32'd0);
    check({tag, " raddr"}, redirect_addr, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    {syscall_req, break_req, teq_req, eret_req, mtc0_req} = '0;
    req_pc = '0; status = '0; epc = '0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check_idle("reset");
    check("reset stall", 32'(stall), 32'd0);
    check("reset cause", 32'(cp0_cause), 32'd0);

    // Enabled syscall: ENTER, FLUSH x2, REDIR, then IDLE.
    status = 32'h0f; req_pc = 32'h0040_0020; syscall_req = 1'b1;
    #1 check("sys accept stall", 32'(stall), 32'd0);
    tick(); syscall_req = 1'b0;
    check("sys exc", 32'(cp0_exception), 32'd1);
    check("sys cause", 32'(cp0_cause), 32'd8);
    check("sys pc", cp0_pc, 32'h0040_0020);
    check("sys enter flush", 32'(flush), 32'd1);
    check("sys enter busy", 32'(busy), 32'd1);
    check("sys enter stall", 32'(stall), 32'd1);
    tick();
    check("sys f1 exc", 32'(cp0_exception), 32'd0);
    check("sys f1 cause", 32'(cp0_cause), 32'd0);
    check("sys f1 pc", cp0_pc, 32'd0);
    check("sys f1 flush", 32'(flush), 32'd1);
    check("sys f1 redir", 32'(pc_redirect), 32'd0);
    tick();
    check("sys f2 flush", 32'(flush), 32'd1);
    check("sys f2 redir", 32'(pc_redirect), 32'd0);
    check("sys f2 busy", 32'(busy), 32'd1);
    tick();
    check("sys redir", 32'(pc_redirect), 32'd1);
    check("sys raddr", redirect_addr, 32'h0040_0004);
    check("sys redir flush", 32'(flush), 32'd1);
    check("sys redir busy", 32'(busy), 32'd1);
    tick();
    check_idle("sys done");

    // Masked break: accepted and dropped.
    status = 32'h0b; break_req = 1'b1;
    #1 check("brk stall", 32'(stall), 32'd0);
    tick(); break_req = 1'b0;
    check_idle("brk dropped");
    check("brk stall2", 32'(stall), 32'd0);

    // Masked syscall blocks mtc0 in the same cycle; mtc0 wins once alone.
    status = 32'h0d; syscall_req = 1'b1; mtc0_req = 1'b1;
    #1 check("mask mtc0 blocked", 32'(cp0_mtc0), 32'd0);
    check("mask stall", 32'(stall), 32'd0);
    tick(); syscall_req = 1'b0;
    #1 check("mtc0 alone", 32'(cp0_mtc0), 32'd1);
    check("mtc0 stall", 32'(stall), 32'd0);
    tick(); mtc0_req = 1'b0;
    check_idle("mtc0 done");

    // ERET: target is EPC sampled at the acceptance edge.
    epc = 32'h0040_0100; eret_req = 1'b1;
    tick(); eret_req = 1'b0; epc = 32'hdead_beef;
    check("eret pulse", 32'(cp0_eret), 32'd1);
    check("eret no exc", 32'(cp0_exception), 32'd0);
    check("eret flush", 32'(flush), 32'd1);
    tick();
    check("eret f1 pulse", 32'(cp0_eret), 32'd0);
    check("eret f1 flush", 32'(flush), 32'd1);
    tick();
    check("eret f2 flush", 32'(flush), 32'd1);
    tick();
    check("eret redir", 32'(pc_redirect), 32'd1);
    check("eret raddr", redirect_addr, 32'h0040_0100);
    tick();
    check_idle("eret done");

    // syscall + mtc0: mtc0 stalled for the whole sequence.
    status = 32'h0f; req_pc = 32'h0040_0040; syscall_req = 1'b1; mtc0_req = 1'b1;
    #1 check("sm accept mtc0", 32'(cp0_mtc0), 32'd0);
    check("sm accept stall", 32'(stall), 32'd0);
    tick(); syscall_req = 1'b0;
    check("sm exc", 32'(cp0_exception), 32'd1);
    check("sm pc", cp0_pc, 32'h0040_0040);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sm busy%0d stall", i), 32'(stall), 32'd1);
      check($sformatf("sm busy%0d mtc0", i), 32'(cp0_mtc0), 32'd0);
      if (i < 3) tick();
    end
    check("sm redir", 32'(pc_redirect), 32'd1);
    tick();
    check("sm idle mtc0", 32'(cp0_mtc0), 32'd1);
    check("sm idle stall", 32'(stall), 32'd0);
    tick(); mtc0_req = 1'b0;
    check_idle("sm done");

    // Reset during FLUSH aborts the sequence with no redirect afterwards.
    req_pc = 32'h0040_0060; syscall_req = 1'b1;
    tick(); syscall_req = 1'b0;
    check("rf exc", 32'(cp0_exception), 32'd1);
    tick();
    check("rf in flush", 32'(flush), 32'd1);
    rst = 1'b0;
    tick(); rst = 1'b1;
    check_idle("rf reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rf post%0d redir", i), 32'(pc_redirect), 32'd0);
      check($sformatf("rf post%0d busy", i), 32'(busy), 32'd0);
    end

    // teq + eret: teq first, eret stalled then served with later EPC.
    req_pc = 32'h0040_0080; epc = 32'h0040_0200; teq_req = 1'b1; eret_req = 1'b1;
    tick(); teq_req = 1'b0; epc = 32'h0040_0300;
    check("teq exc", 32'(cp0_exception), 32'd1);
    check("teq cause", 32'(cp0_cause), 32'd13);
    check("teq pc", cp0_pc, 32'h0040_0080);
    check("teq eret held", 32'(cp0_eret), 32'd0);
    check("teq stall", 32'(stall), 32'd1);
    tick(); tick(); tick();
    check("teq redir", 32'(pc_redirect), 32'd1);
    check("teq raddr", redirect_addr, 32'h0040_0004);
    tick();
    check("te idle stall", 32'(stall), 32'd0);
    tick(); eret_req = 1'b0; epc = 32'h0;
    check("te eret pulse", 32'(cp0_eret), 32'd1);
    check("te eret no exc", 32'(cp0_exception), 32'd0);
    tick(); tick(); tick();
    check("te eret redir", 32'(pc_redirect), 32'd1);
    check("te eret raddr", redirect_addr, 32'h0040_0300);
    tick();
    check_idle("te done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
